// File: rtl/ibex_cheri_scr_file.sv
// Special capability register file: DDC plus the machine-mode SCRs, access-rights checks,
// and MEPCC/MCCSR capture on traps. All responses are registered with one cycle of latency.
module ibex_cheri_scr_file #(
    parameter int unsigned      CAP_W    = 64,
    parameter logic [CAP_W-1:0] DDC_RST  = '1,
    parameter logic [CAP_W-1:0] MTCC_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scr_req_i,
    input  logic [1:0]       scr_op_i,
    input  logic [4:0]       scr_addr_i,
    input  logic [CAP_W-1:0] scr_wdata_i,
    input  logic             scr_wtag_i,
    input  logic [1:0]       priv_lvl_i,
    input  logic             pcc_asr_i,
    output logic             scr_rvalid_o,
    output logic [CAP_W-1:0] scr_rdata_o,
    output logic             scr_rtag_o,
    output logic             scr_illegal_o,
    output logic             scr_asr_viol_o,
    input  logic             exc_save_i,
    input  logic [CAP_W-1:0] exc_pcc_i,
    input  logic             exc_pcc_tag_i,
    input  logic             cheri_exc_i,
    input  logic [4:0]       cheri_cause_i,
    input  logic [5:0]       cheri_reg_i,
    output logic [CAP_W:0]   ddc_o,
    output logic [CAP_W:0]   mtcc_o,
    output logic [CAP_W:0]   mepcc_o,
    output logic [31:0]      mccsr_o
);
    localparam logic [1:0] SCR_NONE      = 2'd0;
    localparam logic [1:0] SCR_WRITE     = 2'd1;
    localparam logic [1:0] SCR_READ      = 2'd2;
    localparam logic [1:0] SCR_READWRITE = 2'd3;
    localparam logic [1:0] PRIV_LVL_M    = 2'b11;

    localparam logic [4:0] SCR_DDC       = 5'h01;
    localparam logic [4:0] SCR_MTCC      = 5'h1C;
    localparam logic [4:0] SCR_MTDC      = 5'h1D;
    localparam logic [4:0] SCR_MSCRATCHC = 5'h1E;
    localparam logic [4:0] SCR_MEPCC     = 5'h1F;

    // Registers hold {tag, capability}
    logic [CAP_W:0] r_ddc, r_mtcc, r_mtdc, r_mscratchc, r_mepcc;
    logic           r_dirty;
    logic [4:0]     r_cause;
    logic [5:0]     r_reg;

    logic           w_active, w_legal, w_viol, w_ok, w_rd, w_wr;
    logic [CAP_W:0] w_rcap, w_wcap;

    assign w_active = scr_req_i && (scr_op_i != SCR_NONE);
    assign w_rd     = (scr_op_i == SCR_READ) || (scr_op_i == SCR_READWRITE);
    assign w_wr     = (scr_op_i == SCR_WRITE) || (scr_op_i == SCR_READWRITE);
    assign w_wcap   = {scr_wtag_i, scr_wdata_i};

    always_comb begin
        w_legal = 1'b1;
        w_rcap  = '0;
        case (scr_addr_i)
            SCR_DDC:       w_rcap = r_ddc;
            SCR_MTCC:      w_rcap = r_mtcc;
            SCR_MTDC:      w_rcap = r_mtdc;
            SCR_MSCRATCHC: w_rcap = r_mscratchc;
            SCR_MEPCC:     w_rcap = r_mepcc;
            default:       w_legal = 1'b0;
        endcase
    end

    // DDC is always accessible; every other implemented SCR is machine-only with ASR
    assign w_viol = w_legal && (scr_addr_i != SCR_DDC) &&
                    !((priv_lvl_i == PRIV_LVL_M) && pcc_asr_i);
    assign w_ok   = w_active && w_legal && !w_viol;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ddc          <= {1'b1, DDC_RST};
            r_mtcc         <= {1'b0, MTCC_RST};
            r_mtdc         <= '0;
            r_mscratchc    <= '0;
            r_mepcc        <= '0;
            r_dirty        <= 1'b0;
            r_cause        <= '0;
            r_reg          <= '0;
            scr_rvalid_o   <= 1'b0;
            scr_rdata_o    <= '0;
            scr_rtag_o     <= 1'b0;
            scr_illegal_o  <= 1'b0;
            scr_asr_viol_o <= 1'b0;
        end else begin
            scr_rvalid_o   <= w_active;
            scr_rdata_o    <= (w_ok && w_rd) ? w_rcap[CAP_W-1:0] : '0;
            scr_rtag_o     <= w_ok && w_rd && w_rcap[CAP_W];
            scr_illegal_o  <= w_active && !w_legal;
            scr_asr_viol_o <= w_active && w_viol;

            if (w_ok && w_wr) begin
                case (scr_addr_i)
                    SCR_DDC:       r_ddc       <= w_wcap;
                    SCR_MTCC:      r_mtcc      <= w_wcap;
                    SCR_MTDC:      r_mtdc      <= w_wcap;
                    SCR_MSCRATCHC: r_mscratchc <= w_wcap;
                    SCR_MEPCC:     if (!exc_save_i) r_mepcc <= w_wcap;
                    default: ;
                endcase
                if (scr_wtag_i) r_dirty <= 1'b1;
            end

            // Trap capture overrides a concurrent SCR write to MEPCC
            if (exc_save_i) begin
                r_mepcc <= {exc_pcc_tag_i, exc_pcc_i};
                if (cheri_exc_i) begin
                    r_cause <= cheri_cause_i;
                    r_reg   <= cheri_reg_i;
                end
            end
        end
    end

    assign ddc_o   = r_ddc;
    assign mtcc_o  = r_mtcc;
    assign mepcc_o = r_mepcc;
    assign mccsr_o = {16'h0, r_reg, r_cause, 3'b000, r_dirty, 1'b1};

endmodule

// File: tb/tb_ibex_cheri_scr_file.sv
// Directed bench for ibex_cheri_scr_file; expected responses are queued at drive time
// and popped when the registered response appears.
module tb_ibex_cheri_scr_file;
    localparam int CAP_W = 64;
    localparam logic [1:0] NONE = 2'd0, WR = 2'd1, RD = 2'd2, RW = 2'd3;
    localparam logic [1:0] PM = 2'b11, PU = 2'b00;

    logic             clk_i = 1'b0, rst_i = 1'b1;
    logic             scr_req_i = 0;
    logic [1:0]       scr_op_i = '0;
    logic [4:0]       scr_addr_i = '0;
    logic [CAP_W-1:0] scr_wdata_i = '0;
    logic             scr_wtag_i = 0;
    logic [1:0]       priv_lvl_i = PM;
    logic             pcc_asr_i = 1;
    logic             scr_rvalid_o, scr_rtag_o, scr_illegal_o, scr_asr_viol_o;
    logic [CAP_W-1:0] scr_rdata_o;
    logic             exc_save_i = 0, exc_pcc_tag_i = 0, cheri_exc_i = 0;
    logic [CAP_W-1:0] exc_pcc_i = '0;
    logic [4:0]       cheri_cause_i = '0;
    logic [5:0]       cheri_reg_i = '0;
    logic [CAP_W:0]   ddc_o, mtcc_o, mepcc_o;
    logic [31:0]      mccsr_o;

    typedef struct {
        logic [CAP_W-1:0] d;
        logic t, ill, vio;
    } rsp_t;
    rsp_t sbq[$];

    int nvec = 0, nerr = 0;

    ibex_cheri_scr_file dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .scr_req_i(scr_req_i), .scr_op_i(scr_op_i), .scr_addr_i(scr_addr_i),
        .scr_wdata_i(scr_wdata_i), .scr_wtag_i(scr_wtag_i),
        .priv_lvl_i(priv_lvl_i), .pcc_asr_i(pcc_asr_i),
        .scr_rvalid_o(scr_rvalid_o), .scr_rdata_o(scr_rdata_o), .scr_rtag_o(scr_rtag_o),
        .scr_illegal_o(scr_illegal_o), .scr_asr_viol_o(scr_asr_viol_o),
        .exc_save_i(exc_save_i), .exc_pcc_i(exc_pcc_i), .exc_pcc_tag_i(exc_pcc_tag_i),
        .cheri_exc_i(cheri_exc_i), .cheri_cause_i(cheri_cause_i), .cheri_reg_i(cheri_reg_i),
        .ddc_o(ddc_o), .mtcc_o(mtcc_o), .mepcc_o(mepcc_o), .mccsr_o(mccsr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; expected response queued now, checked after the next edge
    task automatic step(input string tag, input logic [1:0] op, input logic [4:0] addr,
                        input logic [CAP_W-1:0] wd, input logic wt, input logic [1:0] pv,
                        input logic asr, input logic [CAP_W-1:0] ed, input logic et,
                        input logic eill, input logic evio);
        rsp_t e;
        @(negedge clk_i);
        scr_req_i = 1; scr_op_i = op; scr_addr_i = addr; scr_wdata_i = wd;
        scr_wtag_i = wt; priv_lvl_i = pv; pcc_asr_i = asr;
        sbq.push_back('{d: ed, t: et, ill: eill, vio: evio});
        @(posedge clk_i); #1;
        scr_req_i = 0; scr_op_i = NONE; exc_save_i = 0; cheri_exc_i = 0;
        e = sbq.pop_front();
        chk({tag, ".rvalid"}, 96'(scr_rvalid_o), 96'(1'b1));
        chk({tag, ".rdata"},  96'(scr_rdata_o), 96'(e.d));
        chk({tag, ".rtag"},   96'(scr_rtag_o), 96'(e.t));
        chk({tag, ".illegal"}, 96'(scr_illegal_o), 96'(e.ill));
        chk({tag, ".asrviol"}, 96'(scr_asr_viol_o), 96'(e.vio));
    endtask

    task automatic idle(input string tag);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        scr_req_i = 0; scr_op_i = NONE;
        chk({tag, ".rvalid"}, 96'(scr_rvalid_o), 96'(1'b0));
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        chk("rst.rvalid", 96'(scr_rvalid_o), 96'(1'b0));
        chk("rst.mccsr", 96'(mccsr_o), 96'(32'h1));
        chk("rst.ddc", 96'(ddc_o), 96'({1'b1, {CAP_W{1'b1}}}));
        chk("rst.mtcc", 96'(mtcc_o), 96'(65'h0));
        chk("rst.mepcc", 96'(mepcc_o), 96'(65'h0));

        step("rd_ddc", RD, 5'h01, '0, 0, PM, 1, {CAP_W{1'b1}}, 1, 0, 0);
        step("rw_mscr", RW, 5'h1E, 64'h1234, 1, PM, 1, 64'h0, 0, 0, 0);
        step("rd_mscr", RD, 5'h1E, '0, 0, PM, 1, 64'h1234, 1, 0, 0);
        chk("dirty.mccsr", 96'(mccsr_o), 96'(32'h3));
        idle("pulse");

        step("wr_mtcc_u", WR, 5'h1C, 64'hDEAD, 1, PU, 1, 64'h0, 0, 0, 1);
        step("wr_mtcc_noasr", WR, 5'h1C, 64'hBEEF, 1, PM, 0, 64'h0, 0, 0, 1);
        chk("viol.mtcc", 96'(mtcc_o), 96'(65'h0));
        step("rd_ddc_u", RD, 5'h01, '0, 0, PU, 0, {CAP_W{1'b1}}, 1, 0, 0);

        step("rd_utcc", RD, 5'h04, '0, 0, PM, 1, 64'h0, 0, 1, 0);
        step("rd_pcc", RD, 5'h00, '0, 0, PM, 1, 64'h0, 0, 1, 0);
        step("rd_utcc_u", RD, 5'h04, '0, 0, PU, 0, 64'h0, 0, 1, 0);
        step("wr_pcc", WR, 5'h00, 64'h77, 1, PM, 1, 64'h0, 0, 1, 0);
        chk("ill.ddc", 96'(ddc_o), 96'({1'b1, {CAP_W{1'b1}}}));

        step("wr_mtcc", WR, 5'h1C, 64'h8000_0000_0000_0100, 0, PM, 1, 64'h0, 0, 0, 0);
        chk("wr.mtcc", 96'(mtcc_o), 96'({1'b0, 64'h8000_0000_0000_0100}));
        step("wr_mepcc", WR, 5'h1F, 64'h55, 1, PM, 1, 64'h0, 0, 0, 0);
        chk("wr.mepcc", 96'(mepcc_o), 96'({1'b1, 64'h55}));
        step("rd_mepcc", RD, 5'h1F, '0, 0, PM, 1, 64'h55, 1, 0, 0);

        // Trap capture racing an SCR write to MEPCC: response reports pre-edge value
        exc_save_i = 1; cheri_exc_i = 1; cheri_cause_i = 5'h02; cheri_reg_i = 6'h25;
        exc_pcc_i = 64'hABCD; exc_pcc_tag_i = 1;
        step("exc_rw_mepcc", RW, 5'h1F, 64'h77, 0, PM, 1, 64'h55, 1, 0, 0);
        chk("exc.mepcc", 96'(mepcc_o), 96'({1'b1, 64'hABCD}));
        chk("exc.mccsr", 96'(mccsr_o), 96'(32'h0000_9443));

        // Non-CHERI trap: MEPCC captured, cause/reg untouched
        exc_save_i = 1; cheri_exc_i = 0; cheri_cause_i = 5'h1F; cheri_reg_i = 6'h3F;
        exc_pcc_i = 64'h4242; exc_pcc_tag_i = 0;
        idle("exc2");
        exc_save_i = 0;
        chk("exc2.mepcc", 96'(mepcc_o), 96'({1'b0, 64'h4242}));
        chk("exc2.mccsr", 96'(mccsr_o), 96'(32'h0000_9443));

        scr_req_i = 1; scr_op_i = NONE; scr_addr_i = 5'h1D; scr_wdata_i = 64'h11; scr_wtag_i = 1;
        idle("op_none");
        step("wr_mtdc", WR, 5'h1D, 64'h99, 1, PM, 1, 64'h0, 0, 0, 0);
        step("rd_mtdc", RD, 5'h1D, '0, 0, PM, 1, 64'h99, 1, 0, 0);

        // Reset lands mid READWRITE: nothing retires, all state back to reset values
        @(negedge clk_i);
        scr_req_i = 1; scr_op_i = RW; scr_addr_i = 5'h1D; scr_wdata_i = 64'hF00D; scr_wtag_i = 1;
        #2 rst_i = 1;
        @(posedge clk_i); #1;
        chk("arst.rvalid", 96'(scr_rvalid_o), 96'(1'b0));
        chk("arst.mccsr", 96'(mccsr_o), 96'(32'h1));
        chk("arst.mtcc", 96'(mtcc_o), 96'(65'h0));
        chk("arst.mepcc", 96'(mepcc_o), 96'(65'h0));
        chk("arst.ddc", 96'(ddc_o), 96'({1'b1, {CAP_W{1'b1}}}));
        @(negedge clk_i);
        rst_i = 0; scr_req_i = 0; scr_op_i = NONE;
        step("post_rst_mtdc", RD, 5'h1D, '0, 0, PM, 1, 64'h0, 0, 0, 0);

        // Untagged write leaves dirty clear
        step("wr_mtdc_untag", WR, 5'h1D, 64'h5, 0, PM, 1, 64'h0, 0, 0, 0);
        chk("untag.mccsr", 96'(mccsr_o), 96'(32'h1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
